// File: rtl/mem_sched_pkg.sv
// Shared definitions for the RAM port scheduler.
//   state_e      : scheduler FSM encoding
//   GNT_*        : requester ids as driven on gnt_id_o
//   *_DEF        : default timing parameters
package mem_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_e;

    localparam logic [1:0] GNT_F    = 2'd0;
    localparam logic [1:0] GNT_D    = 2'd1;
    localparam logic [1:0] GNT_L    = 2'd2;
    localparam logic [1:0] GNT_NONE = 2'd3;

    localparam int WAIT_CYCLES_DEF = 1;
    localparam int STARVE_MAX_DEF  = 3;

endpackage

// File: rtl/mem_prio_pick.sv
// Combinational 3-way priority pick for the RAM port.
// Loader beats data beats fetch, except that a starving fetch
// (starve_hit_i) is promoted above data. It never beats the loader.
//   f_req_i, d_req_i, l_req_i : pending requests
//   starve_hit_i              : fetch has lost STARVE_MAX arbitrations in a row
//   win_id_o                  : winning requester id (GNT_NONE when none)
//   win_valid_o               : at least one request is pending
module mem_prio_pick
    import mem_sched_pkg::*;
(
    input  logic       f_req_i,
    input  logic       d_req_i,
    input  logic       l_req_i,
    input  logic       starve_hit_i,
    output logic [1:0] win_id_o,
    output logic       win_valid_o
);

    always_comb begin
        win_id_o    = GNT_NONE;
        win_valid_o = 1'b1;
        if (l_req_i) begin
            win_id_o = GNT_L;
        end else if (f_req_i && starve_hit_i) begin
            win_id_o = GNT_F;
        end else if (d_req_i) begin
            win_id_o = GNT_D;
        end else if (f_req_i) begin
            win_id_o = GNT_F;
        end else begin
            win_valid_o = 1'b0;
        end
    end

endmodule

// File: rtl/mem_port_sched.sv
// Single-port program/data RAM scheduler shared by instruction fetch,
// data access (LDM/STM) and the loader/debug port.
//   clk_sys_i, rst_b_i      : clock, synchronous active-low reset
//   {f,d,l}_req_i           : requests, held until the matching ack
//   {d,l}_we_i, *_addr_i    : write enables and addresses
//   {d,l}_wdata_i           : write data
//   {f,d,l}_ack_o           : one-cycle completion pulses
//   rdata_o                 : captured read data, held until next read
//   busy_o, gnt_id_o        : access in flight / granted requester
//   ram_*                   : RAM port (all outputs registered)
//
// state  | meaning
// IDLE   | arbitrate; a winner loads the RAM registers
// ACCESS | RAM enabled; wait counter runs down, read data captured at 0
// DONE   | ack pulse for the latched requester, then back to IDLE
module mem_port_sched
    import mem_sched_pkg::*;
#(
    parameter int AW          = 8,
    parameter int DW          = 16,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int STARVE_MAX  = STARVE_MAX_DEF
) (
    input  logic          clk_sys_i,
    input  logic          rst_b_i,
    input  logic          f_req_i,
    input  logic          d_req_i,
    input  logic          l_req_i,
    input  logic          d_we_i,
    input  logic          l_we_i,
    input  logic [AW-1:0] f_addr_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [AW-1:0] l_addr_i,
    input  logic [DW-1:0] d_wdata_i,
    input  logic [DW-1:0] l_wdata_i,
    output logic          f_ack_o,
    output logic          d_ack_o,
    output logic          l_ack_o,
    output logic [DW-1:0] rdata_o,
    output logic          busy_o,
    output logic [1:0]    gnt_id_o,
    output logic          ram_en_o,
    output logic          ram_we_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [DW-1:0] ram_wdata_o,
    input  logic [DW-1:0] ram_rdata_i
);

    localparam logic [2:0] WAIT_INIT  = 3'(WAIT_CYCLES);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_e        state_q, state_d;
    logic [2:0]    wait_q, wait_d;
    logic [3:0]    starve_q, starve_d;
    logic [1:0]    gnt_q, gnt_d;
    logic          ram_en_q, ram_en_d;
    logic          ram_we_q, ram_we_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          f_ack_q, f_ack_d;
    logic          d_ack_q, d_ack_d;
    logic          l_ack_q, l_ack_d;
    logic          busy_q, busy_d;

    logic [1:0]    win_id;
    logic          win_valid;
    logic          starve_hit;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    assign starve_hit = f_req_i && (starve_q == STARVE_LIM);

    mem_prio_pick u_pick (
        .f_req_i      (f_req_i),
        .d_req_i      (d_req_i),
        .l_req_i      (l_req_i),
        .starve_hit_i (starve_hit),
        .win_id_o     (win_id),
        .win_valid_o  (win_valid)
    );

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        starve_d    = starve_q;
        gnt_d       = gnt_q;
        ram_en_d    = ram_en_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        rdata_d     = rdata_q;
        busy_d      = busy_q;
        f_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        l_ack_d     = 1'b0;

        // fetch is read-only: it never drives a write or write data
        win_we    = 1'b0;
        win_addr  = f_addr_i;
        win_wdata = '0;
        case (win_id)
            GNT_D: begin
                win_we    = d_we_i;
                win_addr  = d_addr_i;
                win_wdata = d_wdata_i;
            end
            GNT_L: begin
                win_we    = l_we_i;
                win_addr  = l_addr_i;
                win_wdata = l_wdata_i;
            end
            default: ;
        endcase

        case (state_q)
            IDLE: begin
                gnt_d    = GNT_NONE;
                busy_d   = 1'b0;
                ram_en_d = 1'b0;
                ram_we_d = 1'b0;

                if (!f_req_i) begin
                    starve_d = '0;
                end else if (win_valid) begin
                    if (win_id == GNT_F) begin
                        starve_d = '0;
                    end else if (starve_q != STARVE_LIM) begin
                        starve_d = starve_q + 4'd1;
                    end
                end

                if (win_valid) begin
                    gnt_d       = win_id;
                    busy_d      = 1'b1;
                    ram_en_d    = 1'b1;
                    ram_we_d    = win_we;
                    ram_addr_d  = win_addr;
                    ram_wdata_d = win_wdata;
                    wait_d      = WAIT_INIT;
                    state_d     = ACCESS;
                end
            end

            ACCESS: begin
                if (wait_q != 3'd0) begin
                    wait_d = wait_q - 3'd1;
                end else begin
                    if (!ram_we_q) begin
                        rdata_d = ram_rdata_i;
                    end
                    ram_en_d = 1'b0;
                    ram_we_d = 1'b0;
                    f_ack_d  = (gnt_q == GNT_F);
                    d_ack_d  = (gnt_q == GNT_D);
                    l_ack_d  = (gnt_q == GNT_L);
                    state_d  = DONE;
                end
            end

            DONE: begin
                gnt_d   = GNT_NONE;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                gnt_d    = GNT_NONE;
                busy_d   = 1'b0;
                ram_en_d = 1'b0;
                ram_we_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys_i) begin
        if (!rst_b_i) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            starve_q    <= '0;
            gnt_q       <= GNT_NONE;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            f_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            l_ack_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            starve_q    <= starve_d;
            gnt_q       <= gnt_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            f_ack_q     <= f_ack_d;
            d_ack_q     <= d_ack_d;
            l_ack_q     <= l_ack_d;
        end
    end

    assign f_ack_o     = f_ack_q;
    assign d_ack_o     = d_ack_q;
    assign l_ack_o     = l_ack_q;
    assign rdata_o     = rdata_q;
    assign busy_o      = busy_q;
    assign gnt_id_o    = gnt_q;
    assign ram_en_o    = ram_en_q;
    assign ram_we_o    = ram_we_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_wdata_o = ram_wdata_q;

endmodule

// File: doc/mem_port_sched.md
Name: mem_port_sched

Overview:
- Schedules the single-port program/data RAM among three requesters:
  - instruction fetch (driven by the CU in FETCH),
  - data access (LDM/STM),
  - program loader/debug port (used while the CPU is halted).
- Handles arbitration, RAM wait states, read-data capture and a one-cycle acknowledge.
- Sits between the CU/datapath and the RAM. It replaces the direct Meminst address mux.

Parameters:
- AW, 8, address width.
- DW, 16, data width (one instruction word).
- WAIT_CYCLES, 1, extra RAM cycles per access (0..7).
- STARVE_MAX, 3, consecutive lost arbitrations before fetch is forced to win (1..15).

Ports:
- Clock  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-low reset.
- f_req, d_req, l_req  in  1 each  fetch / data / loader request; held until the matching ack.
- d_we, l_we  in  1 each  write enable for data / loader (fetch is read-only).
- f_addr, d_addr, l_addr  in  AW each  request addresses.
- d_wdata, l_wdata  in  DW each  write data.
- f_ack, d_ack, l_ack  out  1 each  one-cycle completion pulse.
- rdata  out  DW  read data; valid in the ack cycle, held until the next capture.
- busy  out  1  high from the grant edge through the ack cycle.
- gnt_id  out  2  granted requester: 0 fetch, 1 data, 2 loader, 3 none.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  AW  RAM address.
- ram_wdata  out  DW  RAM write data.
- ram_rdata  in  DW  RAM read data; valid in the last ACCESS cycle.

Behaviour:
- All outputs are registered.
- Reset (Reset==0 at a rising edge):
  - state=IDLE, gnt_id=3.
  - All acks, busy, ram_en and ram_we = 0.
  - ram_addr, ram_wdata, rdata = 0.
  - starve counter = 0.
- Reset mid-access: the access is abandoned with no ack, and ram_we is low from the next cycle.
- FSM state IDLE:
  - Evaluate requests. Priority is loader > data > fetch.
  - Starvation override: if f_req is high and starve counter == STARVE_MAX, fetch wins over data (not over loader).
  - On a winner: latch id, addr, we and wdata into the RAM output registers; set ram_en=1, busy=1; go to ACCESS with wait counter = WAIT_CYCLES.
  - Fetch always drives ram_we=0.
- FSM state ACCESS:
  - RAM outputs held stable.
  - While wait counter != 0, decrement it.
  - When it is 0: capture ram_rdata into rdata (reads only; writes leave rdata unchanged); clear ram_en and ram_we; go to DONE.
- FSM state DONE:
  - Pulse the ack of the latched id for exactly one cycle; busy stays 1.
  - Next state is IDLE; gnt_id returns to 3 there.
- Latency: req seen in IDLE at cycle t gives ack at cycle t+WAIT_CYCLES+2. RAM is enabled for WAIT_CYCLES+1 cycles.
- Requester rule: req must drop in the cycle after ack. A req still high in IDLE is treated as a new access, so back-to-back accesses cost one idle cycle.
- A requester whose req drops before its ack is still completed; it is not cancelled.
- Starve counter:
  - Increments (saturating at STARVE_MAX) on each IDLE grant to data or loader while f_req=1.
  - Clears on a fetch grant, or in any IDLE cycle with f_req=0.
- Simultaneous requests resolve in one IDLE cycle; the losers keep waiting.
- Inputs are ignored outside IDLE, except ram_rdata.
- A write returns no rdata update.
- Address wrap is not handled here; addresses pass through unmodified.

Decomposition:
- Shared package mem_sched_pkg holds:
  - the state encoding (IDLE=2'b00, ACCESS=2'b01, DONE=2'b10),
  - the gnt_id constants (GNT_F=0, GNT_D=1, GNT_L=2, GNT_NONE=3),
  - the default WAIT_CYCLES and STARVE_MAX.
- One sub-module, mem_prio_pick: combinational 3-way priority pick with the starvation override. Inputs: reqs and starve_hit. Outputs: win_id and win_valid.
- The FSM, counters and RAM registers stay in mem_port_sched.

Test Plan:
- Single fetch, WAIT_CYCLES=1: f_req at t0, f_addr=8'h10, ram_rdata=16'h5A3C.
  - ram_en high t1..t2, ram_we=0.
  - f_ack=1 at t3 only, rdata=16'h5A3C, gnt_id=0 during t1..t3.
- Data write: d_req, d_we=1, d_addr=8'h20, d_wdata=16'h00FF.
  - ram_we=1, ram_addr=8'h20, ram_wdata=16'h00FF for 2 cycles.
  - d_ack pulses at t3; rdata unchanged.
- All three requests at the same time:
  - Service order is loader, data, fetch, each ack exactly 4 cycles apart after the first; no double ack.
- Starvation, STARVE_MAX=3, f_req and d_req held continuously:
  - Three data grants, then a fetch grant, then data again.
  - Counter returns to 0 after the fetch grant.
- Reset low during ACCESS of a data write:
  - Next cycle ram_en=0, ram_we=0, busy=0, gnt_id=3, no d_ack.
  - After reset release with d_req still high, the write restarts from IDLE.
- WAIT_CYCLES=0 with back-to-back fetch (f_req held):
  - Acks at t2 and t5; rdata updates each time.
